// File: rtl/pipeline_pkg.sv
// Shared definitions for the fetch/issue stage and the pipeline2 execute pipeline.
// Instruction word layout: {func[23:20], rs1[19:16], rs2[15:12], rd[11:8], addr[7:0]}.
package pipeline_pkg;

  localparam int REG_W   = 4;
  localparam int FUNC_W  = 4;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 24;

  localparam int FUNC_LSB = 20;
  localparam int RS1_LSB  = 16;
  localparam int RS2_LSB  = 12;
  localparam int RD_LSB   = 8;
  localparam int ADDR_LSB = 0;

  localparam logic [FUNC_W-1:0] FUNC_ADD  = 4'd0;
  localparam logic [FUNC_W-1:0] FUNC_SUB  = 4'd1;
  localparam logic [FUNC_W-1:0] FUNC_MUL  = 4'd2;
  localparam logic [FUNC_W-1:0] FUNC_SLA  = 4'd11;
  localparam logic [FUNC_W-1:0] NOP_FUNC  = 4'd14;
  localparam logic [FUNC_W-1:0] HALT_FUNC = 4'd15;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.func = w[FUNC_LSB +: FUNC_W];
    d.rs1  = w[RS1_LSB  +: REG_W];
    d.rs2  = w[RS2_LSB  +: REG_W];
    d.rd   = w[RD_LSB   +: REG_W];
    d.addr = w[ADDR_LSB +: ADDR_W];
    return d;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// RAW scoreboard: shift register of recently issued destinations.
// Entry 0 is the instruction currently presented downstream.
module hazard_scoreboard #(
  parameter int HAZ_WIN = 3,
  parameter int REG_W   = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push_v,
  input  logic [REG_W-1:0] push_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  output logic             hazard
);

  logic [HAZ_WIN-1:0] v_q;
  logic [REG_W-1:0]   rd_q [HAZ_WIN];

  always_ff @(posedge clk) begin
    if (clr) begin
      v_q <= '0;
      for (int i = 0; i < HAZ_WIN; i++) rd_q[i] <= '0;
    end else begin
      for (int i = HAZ_WIN - 1; i > 0; i--) begin
        v_q[i]  <= v_q[i-1];
        rd_q[i] <= rd_q[i-1];
      end
      v_q[0]  <= push_v;
      rd_q[0] <= push_rd;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (v_q[i] && (rd_q[i] == rs1 || rd_q[i] == rs2)) hazard = 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_fetch_issue.sv
// Fetch/decode/issue stage feeding pipeline2: instruction memory, PC, sequencing FSM
// and registered issue fields, with RAW bubbles inserted by hazard_scoreboard.
//
// state    | meaning
// ST_IDLE  | waiting for start; imem writable; outputs hold a bubble
// ST_RUN   | fetch/issue one word per cycle, bubble on hazard or HALT
// ST_DRAIN | HALT seen; emit HAZ_WIN bubbles so the last writes retire
// ST_DONE  | program finished; imem writable; start reruns from pc=0
module pipeline_fetch_issue
  import pipeline_pkg::*;
#(
  parameter int IMEM_AW = 6,
  parameter int HAZ_WIN = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_waddr,
  input  logic [23:0]        imem_wdata,
  output logic [3:0]         rs1,
  output logic [3:0]         rs2,
  output logic [3:0]         rd,
  output logic [3:0]         func,
  output logic [7:0]         addr,
  output logic               issue_valid,
  output logic [IMEM_AW-1:0] pc,
  output logic               busy,
  output logic               done
);

  localparam int DRAIN_W = $clog2(HAZ_WIN + 1);

  logic [INSTR_W-1:0] imem [2**IMEM_AW];

  state_t             state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  instr_t             fetch;
  logic               idle_like;
  logic               is_halt;
  logic               hazard_raw;
  logic               stall;
  logic               issue;
  logic               push_v;
  logic [REG_W-1:0]   push_rd;
  logic               sb_clr;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign fetch     = decode(imem[pc_q]);
  assign is_halt   = (fetch.func == HALT_FUNC);
  // A NOP word carries no real sources, so it never waits on the scoreboard.
  assign stall     = hazard_raw && (fetch.func != NOP_FUNC);
  assign push_rd   = issue ? fetch.rd : '0;
  assign sb_clr    = !rst_n || idle_like;

  hazard_scoreboard #(
    .HAZ_WIN (HAZ_WIN),
    .REG_W   (REG_W)
  ) u_sb (
    .clk     (clk),
    .clr     (sb_clr),
    .push_v  (push_v),
    .push_rd (push_rd),
    .rs1     (fetch.rs1),
    .rs2     (fetch.rs2),
    .hazard  (hazard_raw)
  );

  always_ff @(posedge clk) begin
    if (imem_we && idle_like) imem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drain_d = drain_q;
    issue   = 1'b0;
    push_v  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN: begin
        if (is_halt) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_W'(HAZ_WIN - 1);
        end else if (!stall) begin
          issue  = 1'b1;
          push_v = 1'b1;
          pc_d   = pc_q + IMEM_AW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_DONE;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !issue) begin
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      func        <= NOP_FUNC;
      addr        <= '0;
      issue_valid <= 1'b0;
    end else begin
      rs1         <= fetch.rs1;
      rs2         <= fetch.rs2;
      rd          <= fetch.rd;
      func        <= fetch.func;
      addr        <= fetch.addr;
      issue_valid <= 1'b1;
    end
  end

  assign pc   = pc_q;
  assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);

endmodule
